neuron_mac: RTL

Streaming multiply-accumulate core that produces the 2*dataWidth pre-activation sum consumed by the `relu` stage. It accepts one (input, weight) pair per valid beat and multiplies them as signed values. Over a frame of numWeight beats it accumulates the products with saturation, adds a bias, and emits the frame sum with a one-cycle valid pulse. It sits between the weight/input fetch logic and the activation function in each neuron.

---
 rtl/neuron_mac_if.sv | 23 ++
 rtl/neuron_mac.sv | 114 +++++++++++
 2 files changed

// File: rtl/neuron_mac_if.sv
// Beat/result bundle between the fetch logic, the MAC core and the activation stage.
// The core takes the slave modport; the fetch side drives the master modport.
interface neuron_mac_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    in_valid;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [DATA_WIDTH-1:0]   in_weight;
  logic [2*DATA_WIDTH-1:0] bias;
  logic                    out_valid;
  logic [2*DATA_WIDTH-1:0] out_sum;
  logic                    out_sat;

  modport master (
    output in_valid, in_data, in_weight, bias,
    input  out_valid, out_sum, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_weight, bias,
    output out_valid, out_sum, out_sat
  );
endinterface

// File: rtl/neuron_mac.sv
// Three-stage signed multiply / saturating frame accumulate / bias add.
// Emits one pre-activation sum per NUM_WEIGHT beats, with a sticky saturation flag.
module neuron_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WEIGHT = 784
) (
  input  logic         clk,
  input  logic         rst,
  neuron_mac_if.slave  io_mac
);
  localparam int SUM_W = 2 * DATA_WIDTH;
  localparam int CNT_W = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_WEIGHT - 1);

  typedef logic signed [SUM_W-1:0] sum_t;
  typedef struct packed {
    logic clamp;
    sum_t sum;
  } sat_res_t;

  // Overflow only when both operands share a sign and the wrapped result does not.
  function automatic sat_res_t sat_add(input sum_t a, input sum_t b);
    sat_res_t r;
    r.sum   = a + b;
    r.clamp = (a[SUM_W-1] == b[SUM_W-1]) && (r.sum[SUM_W-1] != a[SUM_W-1]);
    if (r.clamp)
      r.sum = a[SUM_W-1] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
    return r;
  endfunction

  sum_t             r_prod;
  logic             r_p_valid;
  sum_t             r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sticky;
  sum_t             r_final;
  sum_t             r_bias;
  logic             r_final_sat;
  logic             r_f_valid;
  sum_t             r_out_sum;
  logic             r_out_sat;
  logic             r_out_valid;

  sum_t     w_prod;
  sat_res_t w_acc_add;
  sat_res_t w_bias_add;
  logic     w_last;

  assign w_prod     = sum_t'($signed(io_mac.in_data)) * sum_t'($signed(io_mac.in_weight));
  assign w_acc_add  = sat_add(r_acc, r_prod);
  assign w_bias_add = sat_add(r_final, r_bias);
  assign w_last     = r_p_valid && (r_cnt == LAST_BEAT);

  // NOTE: every register here is small control/datapath state, so all of it is
  // async-reset and updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod    <= '0;
      r_p_valid <= 1'b0;
    end else begin
      r_p_valid <= io_mac.in_valid;
      if (io_mac.in_valid)
        r_prod <= w_prod;
    end
  end

  // The final beat hands the saturated total to stage 3 and rearms the accumulator,
  // so a following frame can start on the very next product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sticky    <= 1'b0;
      r_final     <= '0;
      r_bias      <= '0;
      r_final_sat <= 1'b0;
      r_f_valid   <= 1'b0;
    end else begin
      r_f_valid <= w_last;
      if (r_p_valid) begin
        if (w_last) begin
          r_acc       <= '0;
          r_cnt       <= '0;
          r_sticky    <= 1'b0;
          r_final     <= w_acc_add.sum;
          r_bias      <= io_mac.bias;
          r_final_sat <= r_sticky | w_acc_add.clamp;
        end else begin
          r_acc    <= w_acc_add.sum;
          r_cnt    <= r_cnt + CNT_W'(1);
          r_sticky <= r_sticky | w_acc_add.clamp;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_out_valid <= r_f_valid;
      if (r_f_valid) begin
        r_out_sum <= w_bias_add.sum;
        r_out_sat <= r_final_sat | w_bias_add.clamp;
      end
    end
  end

  assign io_mac.out_valid = r_out_valid;
  assign io_mac.out_sum   = r_out_sum;
  assign io_mac.out_sat   = r_out_sat;
endmodule
